async_fifo: RTL and testbench



---
 rtl/async_fifo.sv | 83 ++++++++
 tb/tb_async_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Single-clock register-array FIFO with full/empty status
// and sticky overflow/underflow flags.
module async_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  full_o,
  output logic                  overflow_o,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  empty_o,
  output logic                  underflow_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  wr_acc, rd_acc;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                   (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);

  assign wr_acc = wr_en_i && !full_o;
  assign rd_acc = rd_en_i && !empty_o;

  assign rd_data_o   = rd_data_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_d       = mem_q;
    if (wr_acc) begin
      mem_d[wr_ptr_q[ADDR_WIDTH-1:0]] = wr_data_i;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
    end
    if (wr_en_i && full_o) overflow_d = 1'b1;
    if (rd_en_i && empty_o) underflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: stimulus pushes expected
// read data, a monitor pops it on every accepted read.
module tb_async_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       ovf;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       unf;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  int  cnt;
  bit  m_ovf, m_unf;

  async_fifo #(
    .DEPTH(16),
    .DATA_WIDTH(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .full_o     (full),
    .overflow_o (ovf),
    .rd_en_i    (rd_en),
    .rd_data_o  (rd_data),
    .empty_o    (empty),
    .underflow_o(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a read is presented when requested while not empty.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && rd_en === 1'b1 && empty === 1'b0) begin
      #1;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underrun: got %0h expected none", rd_data);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (rd_data !== e) begin
          failures++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  task automatic chk_flags(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
    chk({tag, ".full"}, 32'(full), 32'(cnt == 16));
    chk({tag, ".overflow"}, 32'(ovf), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(unf), 32'(m_unf));
  endtask

  // Entered and left on a falling edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    bit wa, ra;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    wa = w && (cnt < 16);
    ra = r && (cnt > 0);
    if (w && !wa) m_ovf = 1'b1;
    if (r && !ra) m_unf = 1'b1;
    if (wa) sb.push_back(d);
    cnt = cnt + int'(wa) - int'(ra);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hEE;
    rd_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    sb.delete();
    chk_flags("reset");
    chk("reset.rd_data", 32'(rd_data), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = 8'h00;
    cnt = 0;
    @(negedge clk);
    do_reset();

    // Fill 16, drain 16.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i * 29 + 3), 1'b0);
      chk_flags("fill16");
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk_flags("drain16");
    end

    // Write 5, read 5.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      chk_flags("w5");
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk_flags("r5");
    end

    // 17 writes: the last is rejected.
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b0);
      chk_flags("w17");
    end
    cycle(1'b0, 8'h00, 1'b0);
    chk_flags("ovf_hold");
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk_flags("r16");
    end

    // Underflow keeps the last read data.
    do_reset();
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk_flags("r3");
    end
    chk("unf.rd_data_hold", 32'(rd_data), 32'h22);

    // Wrap with gaps and simultaneous requests.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(i * 7 + 1), (i >= 3) && (i % 4 != 1));
      chk_flags("wrap");
      for (int g = 0; g < (i % 10) + 1; g++) cycle(1'b0, 8'h00, 1'b0);
    end
    while (cnt > 0) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk_flags("wrap_drain");
    end

    // Simultaneous access with 8 stored keeps 8.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    cycle(1'b1, 8'h99, 1'b1);
    chk_flags("sim8");
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      chk_flags("sim8_drain");
    end

    // Simultaneous on full and on empty.
    do_reset();
    cycle(1'b1, 8'h5A, 1'b1);
    chk_flags("sim_empty");
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    cycle(1'b1, 8'hF0, 1'b1);
    chk_flags("sim_full");
    while (cnt > 0) cycle(1'b0, 8'h00, 1'b1);
    chk_flags("sim_full_drain");

    // Mid-operation reset.
    do_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0);
    cycle(1'b1, 8'hB0, 1'b1);
    do_reset();
    cycle(1'b0, 8'h00, 1'b1);
    chk_flags("post_reset_rd");
    chk("post_reset.rd_data", 32'(rd_data), 32'h0);

    chk("sb_leftover", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
